prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream consumer of the three-operand multiplier's 14-bit final product (P2).
- Accepts a stream of products over a valid/ready handshake and sums a programmable number of terms (1..15).
- Presents the registered sum with a term count and a sticky overflow flag.
- Sits between the combinational multiplier and any result register or readout logic.

Parameters:
- IN_W, 14: product input width; matches the multiplier's P2 width.
- ACC_W, 18: accumulator width; 18 holds 15 × 16383 without overflow.
- CNT_W, 4: width of the term counter and of num_terms.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns block to IDLE.
- num_terms  input  CNT_W  terms to sum per result; sampled on the first accepted product.
- in_valid  input  1  in_prod valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  IN_W  product from the multiplier.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer takes the sum.
- out_sum  output  ACC_W  accumulated sum, registered.
- out_count  output  CNT_W  number of terms summed into out_sum.
- overflow  output  1  sticky; a carry left ACC_W during the current result.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: state=IDLE; in_ready=0 during reset, 1 after release; out_valid=0; out_sum=0; out_count=0; overflow=0; internal target=0.
- Handshake rules:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - in_prod is zero-extended to ACC_W before each add.
  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- FSM state IDLE:
  - in_ready=1, out_valid=0.
  - On input transfer: target = (num_terms==0 ? 1 : num_terms); out_sum=in_prod; out_count=1; overflow=0.
  - Next state is DONE if target==1, else ACCUM.
- FSM state ACCUM:
  - in_ready=1.
  - Each transfer: out_sum = out_sum + in_prod (mod 2^ACC_W); out_count += 1; overflow |= carry.
  - When the new out_count equals target, go to DONE on the same edge.
  - Cycles with in_valid=0 hold all state; bubbles are allowed.
- FSM state DONE:
  - in_ready=0, out_valid=1; out_sum, out_count and overflow held stable.
  - On output transfer, go to IDLE.
  - out_sum, out_count and overflow keep their last values until the next IDLE transfer overwrites them.
- Latency: out_valid rises 1 cycle after the final input transfer.
  - Throughput: 1 product/cycle while accumulating, plus at least 1 cycle in DONE per result.
- clear:
  - Takes priority over every transfer in the same cycle.
  - Next state IDLE; out_valid=0; out_sum=0; out_count=0; overflow=0.
  - An input or output handshake coincident with clear is discarded.
- num_terms changes mid-accumulation are ignored; target is latched only in IDLE.
- Reset mid-operation: immediate return to reset values, independent of clk.
- Wrap-around: without saturation, the sum wraps modulo 2^ACC_W and overflow goes to 1 on the first carry.

Optional Feature:
- Macro: PROD_ACCUM_SAT_EN.
- Defined: on carry, out_sum clamps to 2^ACC_W−1 and stays there for the remainder of the result. overflow still asserts.
- Undefined: modulo wrap as in Behaviour; no saturation logic synthesised.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_sum=0, out_count=0 immediately. in_ready=1 on the first edge after release.
- Basic sum: num_terms=3, products 225, 57, 16383 back-to-back -> out_valid 1 cycle after the last transfer; out_sum=16665, out_count=3, overflow=0.
- Single term and zero: num_terms=1, prod 100 -> DONE after 1 transfer, out_sum=100. num_terms=0, prod 7 -> treated as 1, out_sum=7, out_count=1.
- Backpressure and bubbles: num_terms=2, in_valid gaps of 3 cycles, out_ready=0 for 5 cycles -> in_ready=0 and out_sum stable throughout DONE. Sum accepted on out_ready=1, then IDLE.
- Overflow, with ACC_W=15 override and num_terms=3 of 16383:
  - Wrap build: out_sum=16381, overflow=1.
  - PROD_ACCUM_SAT_EN build: out_sum=32767, overflow=1.
- Clear mid-stream: num_terms=4, 2 products accepted, then clear=1 with in_valid=1 -> that product is dropped; state IDLE, out_sum=0. A fresh 1-term result of 5 gives out_sum=5.

Source files
------------

// File: rtl/prod_accum.sv
// ============================================================================
// Module   : prod_accum
// Summary  : Handshaked accumulator that sums 1..15 multiplier products per result.
//            Define PROD_ACCUM_SAT_EN to clamp the sum on carry instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prod_accum #(
  parameter int IN_W  = 14,
  parameter int ACC_W = 18,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             ovf_q, ovf_d;
  logic             rdy_en_q;

  logic             w_first;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [ACC_W:0]   w_add;
  logic             w_carry;
  logic [ACC_W-1:0] w_sum_new;
  logic [CNT_W-1:0] w_cnt_new;
  logic [CNT_W-1:0] w_tgt_eff;
  logic             w_ovf_new;
  logic             w_last;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_first    = (state_q == S_IDLE);

  // The first term of a result starts from a zero base so IDLE and ACCUM share one adder.
  assign w_add     = {1'b0, (w_first ? {ACC_W{1'b0}} : sum_q)}
                   + {{(ACC_W + 1 - IN_W){1'b0}}, in_prod};
  assign w_carry   = w_add[ACC_W];
  assign w_cnt_new = (w_first ? {CNT_W{1'b0}} : cnt_q) + c_one;
  assign w_tgt_eff = w_first ? ((num_terms == '0) ? c_one : num_terms) : tgt_q;
  assign w_ovf_new = w_carry | (~w_first & ovf_q);
  assign w_last    = (w_cnt_new == w_tgt_eff);

`ifdef PROD_ACCUM_SAT_EN
  assign w_sum_new = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
  assign w_sum_new = w_add[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: if (w_in_xfer) state_d = w_last ? S_DONE : S_ACCUM;
        S_DONE:          if (w_out_xfer) state_d = S_IDLE;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  // in_ready is held low until the first clock after reset release.
  always_comb begin
    in_ready  = rdy_en_q & (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    ovf_d = ovf_q;
    if (clear) begin
      sum_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (w_in_xfer) begin
      sum_d = w_sum_new;
      cnt_d = w_cnt_new;
      tgt_d = w_tgt_eff;
      ovf_d = w_ovf_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
      tgt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// ============================================================================
// Module   : tb_prod_accum
// Summary  : Directed bench for prod_accum at ACC_W=18 and ACC_W=15 against a true-sum model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  num_terms = 4'd0;
  logic        in_valid = 1'b0;
  logic [13:0] in_prod = 14'd0;
  logic        out_ready = 1'b0;

  logic        rdy18, val18, ovf18;
  logic [17:0] sum18;
  logic [3:0]  cnt18;
  logic        rdy15, val15, ovf15;
  logic [14:0] sum15;
  logic [3:0]  cnt15;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

`ifdef PROD_ACCUM_SAT_EN
  localparam longint c_ovf15_sum = 32767;
`else
  localparam longint c_ovf15_sum = 16381;
`endif

  always #5 clk = ~clk;

  prod_accum u_dut18 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(rdy18), .in_prod(in_prod),
    .out_valid(val18), .out_ready(out_ready), .out_sum(sum18),
    .out_count(cnt18), .overflow(ovf18)
  );

  prod_accum #(.ACC_W(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(rdy15), .in_prod(in_prod),
    .out_valid(val15), .out_ready(out_ready), .out_sum(sum15),
    .out_count(cnt15), .overflow(ovf15)
  );

  // Model keeps the exact mathematical sum; width effects are derived only when comparing.
  longint m_true = 0;
  int     m_cnt = 0;
  int     m_tgt = 0;
  bit     m_run = 1'b0;
  bit     m_done = 1'b0;
  bit     m_live = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_true = 0; m_cnt = 0; m_tgt = 0;
      m_run = 1'b0; m_done = 1'b0; m_live = 1'b0;
    end else begin
      if (clear) begin
        m_true = 0; m_cnt = 0; m_run = 1'b0; m_done = 1'b0;
      end else if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_live && in_valid) begin
        if (!m_run) begin
          m_tgt  = (num_terms == 0) ? 1 : int'(num_terms);
          m_true = longint'(in_prod);
          m_cnt  = 1;
          m_run  = 1'b1;
        end else begin
          m_true = m_true + longint'(in_prod);
          m_cnt  = m_cnt + 1;
        end
        if (m_cnt == m_tgt) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
      m_live = 1'b1;
    end
  end

  function automatic longint exp_sum(input int w);
    longint maxv;
    maxv = (64'sd1 <<< w) - 1;
`ifdef PROD_ACCUM_SAT_EN
    return (m_true > maxv) ? maxv : m_true;
`else
    return m_true & maxv;
`endif
  endfunction

  function automatic longint exp_ovf(input int w);
    return (m_true > ((64'sd1 <<< w) - 1)) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready18",  rdy18, (m_live && !m_done) ? 1 : 0);
      chk("out_valid18", val18, m_done ? 1 : 0);
      chk("out_sum18",   sum18, exp_sum(18));
      chk("out_count18", cnt18, m_cnt);
      chk("overflow18",  ovf18, exp_ovf(18));
      chk("in_ready15",  rdy15, (m_live && !m_done) ? 1 : 0);
      chk("out_valid15", val15, m_done ? 1 : 0);
      chk("out_sum15",   sum15, exp_sum(15));
      chk("out_count15", cnt15, m_cnt);
      chk("overflow15",  ovf15, exp_ovf(15));
    end
  end

  task automatic put(input int p);
    in_valid = 1'b1;
    in_prod  = 14'(p);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1 chk("lit_rdy_in_reset", rdy18, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rdy_after_rst", rdy18, 1);

    // Basic three-term sum, back to back.
    num_terms = 4'd3;
    put(225); in_valid = 1'b1; in_prod = 14'd57; @(negedge clk);
    in_prod = 14'd16383; @(negedge clk); in_valid = 1'b0;
    chk("lit_basic_valid", val18, 1);
    chk("lit_basic_sum",   sum18, 16665);
    chk("lit_basic_count", cnt18, 3);
    chk("lit_basic_ovf",   ovf18, 0);
    @(negedge clk);
    take();
    chk("lit_basic_idle", val18, 0);

    // Single term, then num_terms=0 treated as one.
    num_terms = 4'd1;
    put(100);
    chk("lit_one_sum", sum18, 100);
    chk("lit_one_valid", val18, 1);
    take();
    num_terms = 4'd0;
    put(7);
    chk("lit_zero_sum", sum18, 7);
    chk("lit_zero_count", cnt18, 1);
    take();

    // Bubbles, ignored num_terms change, and output backpressure with a pending input.
    num_terms = 4'd2;
    put(10);
    repeat (3) @(negedge clk);
    num_terms = 4'd9;
    put(20);
    in_valid = 1'b1; in_prod = 14'd999;
    for (int i = 0; i < 5; i++) begin
      chk("lit_bp_ready", rdy18, 0);
      chk("lit_bp_sum", sum18, 30);
      @(negedge clk);
    end
    take();
    in_valid = 1'b0;
    chk("lit_bp_idle", val18, 0);
    chk("lit_bp_hold", sum18, 30);

    // Overflow: wraps or clamps at 15 bits, fits at 18 bits.
    num_terms = 4'd3;
    put(16383); put(16383); put(16383);
    chk("lit_ovf_sum15", sum15, c_ovf15_sum);
    chk("lit_ovf_flag15", ovf15, 1);
    chk("lit_ovf_sum18", sum18, 49149);
    chk("lit_ovf_flag18", ovf18, 0);
    take();

    // Clear drops a coincident input transfer.
    num_terms = 4'd4;
    put(1); put(2);
    clear = 1'b1; in_valid = 1'b1; in_prod = 14'd50;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("lit_clr_sum", sum18, 0);
    chk("lit_clr_valid", val18, 0);
    chk("lit_clr_ready", rdy18, 1);
    num_terms = 4'd1;
    put(5);
    chk("lit_clr_fresh", sum18, 5);
    take();

    // Asynchronous reset mid-cycle while a result is presented.
    put(42);
    chk("lit_ar_valid_pre", val18, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_ar_valid", val18, 0);
    chk("lit_ar_sum", sum18, 0);
    chk("lit_ar_count", cnt18, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_ar_ready", rdy18, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
